// File: rtl/qc_syndrome_accum_if.sv
// Block stream and syndrome result bundle for qc_syndrome_accum.
// The master side feeds circulant blocks; the slave side returns syndromes.
interface qc_syndrome_accum_if #(
    parameter int Z  = 5,
    parameter int SW = 3
);
    logic [Z-1:0]  blk_in;
    logic [SW-1:0] blk_shift;
    logic          blk_valid;
    logic          blk_last;
    logic          blk_ready;
    logic [Z-1:0]  syndrome;
    logic          syn_valid;
    logic          syn_zero;
    logic          len_err;

    modport master (
        output blk_in, blk_shift, blk_valid, blk_last,
        input  blk_ready, syndrome, syn_valid, syn_zero, len_err
    );

    modport slave (
        input  blk_in, blk_shift, blk_valid, blk_last,
        output blk_ready, syndrome, syn_valid, syn_zero, len_err
    );
endinterface

// File: rtl/qc_syndrome_accum.sv
// Row-layer syndrome accumulator for QC-LDPC receive data.
// Rotates each Z-bit circulant block and XORs it into a partial syndrome.
module qc_syndrome_accum #(
    parameter int Z    = 5,
    parameter int COLS = 5,
    parameter int SW   = 3,
    parameter int CW   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    qc_syndrome_accum_if.slave bus
);
    typedef enum logic {ACC, DONE} state_t;

    localparam logic [SW-1:0] ZS   = SW'(Z);
    localparam logic [CW-1:0] LAST = CW'(COLS - 1);

    state_t         state;
    logic [Z-1:0]   acc;
    logic [CW-1:0]  cnt;
    logic [2*Z-1:0] dbl;
    logic [SW-1:0]  sh;
    logic           is_null;
    logic [Z-1:0]   rot;
    logic [Z-1:0]   nxt;
    logic           at_end;
    logic           accept;
    logic           term;

    // Rotation via a doubled vector; null entries contribute nothing.
    always_comb begin
        dbl     = {bus.blk_in, bus.blk_in};
        is_null = (bus.blk_shift >= ZS);
        sh      = is_null ? '0 : bus.blk_shift;
        rot     = is_null ? '0 : dbl[sh +: Z];
        nxt     = acc ^ rot;
        at_end  = (cnt == LAST);
        accept  = bus.blk_valid & bus.blk_ready;
        term    = bus.blk_last | at_end;
    end

    assign bus.blk_ready = ce & ~rst & (state == ACC);
    assign bus.syn_valid = ce & ~rst & (state == DONE);

    // Accumulate, latch the result on the terminating block, then clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACC;
            acc          <= '0;
            cnt          <= '0;
            bus.syndrome <= '0;
            bus.syn_zero <= 1'b0;
            bus.len_err  <= 1'b0;
        end else if (ce) begin
            unique case (state)
                ACC: begin
                    if (accept) begin
                        acc <= nxt;
                        cnt <= cnt + CW'(1);
                        if (term) begin
                            bus.syndrome <= nxt;
                            bus.syn_zero <= (nxt == '0);
                            bus.len_err  <= bus.blk_last ^ at_end;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_qc_syndrome_accum.sv
// Scoreboard bench for qc_syndrome_accum with directed row vectors.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_qc_syndrome_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;

    qc_syndrome_accum_if #(.Z(5), .SW(3)) bus ();

    qc_syndrome_accum #(.Z(5), .COLS(5), .SW(3), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] syn;
        logic       z;
        logic       le;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   pulses = 0;
    int   pushed = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, want, $time);
        end
    endtask

    task automatic push(input logic [4:0] s, input logic z, input logic le);
        exp_t e;
        e.syn = s;
        e.z   = z;
        e.le  = le;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: pop and compare on every syndrome pulse; police ce-low cycles.
    always @(negedge clk) begin
        exp_t e;
        if (bus.syn_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_syn_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("syndrome", 32'(bus.syndrome), 32'(e.syn));
                chk("syn_zero", 32'(bus.syn_zero), 32'(e.z));
                chk("len_err", 32'(bus.len_err), 32'(e.le));
            end
        end
        if (!rst && !ce) begin
            chk("ready_ce_low", 32'(bus.blk_ready), 32'd0);
            chk("syn_valid_ce_low", 32'(bus.syn_valid), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] b, input logic [2:0] s,
                        input logic l, input bit gaps);
        logic ok;
        int   n;
        n = 0;
        bus.blk_in    = b;
        bus.blk_shift = s;
        bus.blk_last  = l;
        bus.blk_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = bus.blk_valid & bus.blk_ready;
            step();
            if (ok) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
            if (gaps) begin
                ce            = 1'($urandom_range(0, 1));
                bus.blk_valid = 1'($urandom_range(0, 1));
                bus.blk_in    = 1'($urandom_range(0, 1)) ? b : ~b;
                if (bus.blk_valid) bus.blk_in = b;
            end
        end
        if (gaps) begin
            ce            = 1'($urandom_range(0, 1));
            bus.blk_valid = 1'($urandom_range(0, 1));
            bus.blk_in    = 5'h1f;
        end
    endtask

    task automatic idle(input int k);
        bus.blk_valid = 1'b0;
        bus.blk_last  = 1'b0;
        ce            = 1'b1;
        repeat (k) step();
    endtask

    task automatic do_reset(input int k);
        rst           = 1'b1;
        bus.blk_valid = 1'b0;
        repeat (k) begin
            @(negedge clk);
            chk("rst_ready", 32'(bus.blk_ready), 32'd0);
            chk("rst_syn_valid", 32'(bus.syn_valid), 32'd0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_syndrome", 32'(bus.syndrome), 32'd0);
        chk("rst_syn_zero", 32'(bus.syn_zero), 32'd0);
        chk("rst_len_err", 32'(bus.len_err), 32'd0);
        step();
    endtask

    task automatic zero_row();
        for (int i = 0; i < 5; i++)
            send(5'b00000, 3'(i), (i == 4), 1'b0);
    endtask

    initial begin
        bus.blk_in    = '0;
        bus.blk_shift = '0;
        bus.blk_valid = 1'b0;
        bus.blk_last  = 1'b0;
        step();
        do_reset(2);

        push(5'b00000, 1'b1, 1'b0);
        zero_row();
        @(negedge clk);
        chk("latency_pulse", 32'(bus.syn_valid), 32'd1);
        step();
        idle(2);

        push(5'b01000, 1'b0, 1'b0);
        send(5'b00001, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            send(5'b00000, 3'd0, (i == 3), 1'b0);
        idle(2);

        push(5'b00000, 1'b1, 1'b0);
        send(5'b10110, 3'd1, 1'b0, 1'b0);
        send(5'b10110, 3'd1, 1'b0, 1'b0);
        send(5'b11111, 3'd7, 1'b0, 1'b0);
        send(5'b00000, 3'd0, 1'b0, 1'b0);
        send(5'b00000, 3'd0, 1'b1, 1'b0);
        idle(1);

        push(5'b11111, 1'b0, 1'b0);
        send(5'b10110, 3'd1, 1'b0, 1'b0);
        send(5'b10110, 3'd1, 1'b0, 1'b0);
        send(5'b11111, 3'd0, 1'b0, 1'b0);
        send(5'b00000, 3'd0, 1'b0, 1'b0);
        send(5'b00000, 3'd0, 1'b1, 1'b0);
        idle(1);

        push(5'b11000, 1'b0, 1'b0);
        send(5'b10110, 3'd1, 1'b0, 1'b0);
        send(5'b11001, 3'd4, 1'b0, 1'b0);
        send(5'b10101, 3'd5, 1'b0, 1'b0);
        send(5'b00000, 3'd3, 1'b0, 1'b0);
        send(5'b00000, 3'd0, 1'b1, 1'b0);
        idle(1);

        push(5'b00111, 1'b0, 1'b1);
        send(5'b00001, 3'd0, 1'b0, 1'b0);
        send(5'b00010, 3'd0, 1'b0, 1'b0);
        send(5'b00100, 3'd0, 1'b1, 1'b0);
        idle(1);

        push(5'b01000, 1'b0, 1'b0);
        send(5'b00001, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            send(5'b00000, 3'd0, (i == 3), 1'b0);
        idle(1);

        push(5'b01111, 1'b0, 1'b1);
        send(5'b11111, 3'd3, 1'b0, 1'b0);
        send(5'b00001, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            send(5'b00000, 3'd0, 1'b0, 1'b0);
        idle(1);

        push(5'b01000, 1'b0, 1'b0);
        send(5'b00001, 3'd2, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            send(5'b00000, 3'd0, (i == 3), 1'b1);
        ce            = 1'b0;
        bus.blk_valid = 1'b1;
        repeat (3) step();
        idle(2);

        send(5'b11111, 3'd0, 1'b0, 1'b0);
        send(5'b10101, 3'd2, 1'b0, 1'b0);
        idle(1);
        do_reset(1);
        push(5'b00000, 1'b1, 1'b0);
        zero_row();
        idle(4);

        chk("pulse_count", 32'(pulses), 32'(pushed));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
